ob_drain_streamer: RTL and testbench

- Sits directly downstream of the matrix multiplier's output buffer SRAM (COL×WIDTH words written by the array).
- After a compute run completes, reads a programmable window of that SRAM through its single-port interface and streams each word out on a valid/ready master port with backpressure.
- Signals completion, and optionally a checksum, to the test controller.

---
 rtl/ob_drain_streamer.sv | 173 +++++++++++++++++
 tb/tb_ob_drain_streamer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ob_drain_streamer.sv
// Streams a window of the output-buffer SRAM onto a valid/ready master port.
// Optional running XOR checksum output (csum_o) is built when OB_DRAIN_CSUM_EN is defined.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start_i; the first read is issued on the launch edge
// S_RUN  | issuing reads, filling the 2-entry skid FIFO, streaming words out
// S_DONE | one-cycle completion pulse on done_o
module ob_drain_streamer #(
    parameter  int WIDTH  = 8,
    parameter  int COL    = 4,
    parameter  int O_SIZE = 256,
    localparam int AW     = $clog2(O_SIZE),
    localparam int DW     = COL * WIDTH
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [AW:0]   num_words_i,
    output logic          ob_mem_cenb_o,
    output logic          ob_mem_wenb_o,
    output logic [AW-1:0] ob_mem_addr_o,
    input  logic [DW-1:0] ob_mem_data_i,
    output logic [DW-1:0] m_data_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic          m_last_o,
    output logic          busy_o,
    output logic          done_o
`ifdef OB_DRAIN_CSUM_EN
    ,
    output logic [DW-1:0] csum_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q;
    state_t        state_d;

    logic [AW:0]   num_q;
    logic [AW:0]   issued_q;
    logic [AW:0]   accepted_q;
    logic [AW-1:0] ptr_q;
    logic          cenb_q;
    logic [AW-1:0] addr_q;
    logic          rd_d1_q;

    logic [DW-1:0] skid_mem [2];
    logic          skid_wr_q;
    logic          skid_rd_q;
    logic [1:0]    skid_cnt_q;

    logic          launch;
    logic          issue;
    logic [AW-1:0] issue_addr;
    logic [AW-1:0] next_ptr;
    logic [2:0]    occupancy;
    logic          hs;
    logic          last_hs;
    logic          head_is_last;

    assign launch = (state_q == S_IDLE) && start_i;

    // Reads in flight (enable cycle or data cycle) plus buffered words never exceed 2.
    assign occupancy = {1'b0, skid_cnt_q} + {2'b00, ~cenb_q} + {2'b00, rd_d1_q};

    always_comb begin
        issue      = 1'b0;
        issue_addr = ptr_q;
        if (launch) begin
            issue      = (num_words_i != '0);
            issue_addr = base_addr_i;
        end else if (state_q == S_RUN) begin
            issue = (issued_q < num_q) && (occupancy < 3'd2);
        end
    end

    assign next_ptr     = (issue_addr == AW'(O_SIZE - 1)) ? '0 : issue_addr + 1'b1;
    assign m_valid_o    = (skid_cnt_q != 2'd0);
    assign m_data_o     = m_valid_o ? skid_mem[skid_rd_q] : '0;
    assign head_is_last = (accepted_q == num_q - 1'b1);
    assign m_last_o     = m_valid_o && head_is_last;
    assign hs           = m_valid_o && m_ready_i;
    assign last_hs      = hs && head_is_last;

    assign ob_mem_cenb_o = cenb_q;
    assign ob_mem_addr_o = addr_q;
    assign ob_mem_wenb_o = 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = (num_words_i != '0) ? S_RUN : S_DONE;
            S_RUN:  if (last_hs) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != S_IDLE);
        done_o = (state_q == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            num_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            ptr_q      <= '0;
            cenb_q     <= 1'b1;
            addr_q     <= '0;
            rd_d1_q    <= 1'b0;
            skid_wr_q  <= 1'b0;
            skid_rd_q  <= 1'b0;
            skid_cnt_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                skid_mem[i] <= '0;
            end
        end else begin
            cenb_q  <= ~issue;
            rd_d1_q <= ~cenb_q;
            if (issue) begin
                addr_q <= issue_addr;
                ptr_q  <= next_ptr;
            end

            if (launch) begin
                num_q      <= num_words_i;
                accepted_q <= '0;
                issued_q   <= issue ? (AW+1)'(1) : '0;
            end else begin
                if (issue) issued_q <= issued_q + 1'b1;
                if (hs)    accepted_q <= accepted_q + 1'b1;
            end

            // SRAM data is valid the cycle after the enable cycle.
            if (rd_d1_q) begin
                skid_mem[skid_wr_q] <= ob_mem_data_i;
                skid_wr_q           <= ~skid_wr_q;
            end
            if (hs) skid_rd_q <= ~skid_rd_q;
            skid_cnt_q <= skid_cnt_q + {1'b0, rd_d1_q} - {1'b0, hs};
        end
    end

`ifdef OB_DRAIN_CSUM_EN
    logic [DW-1:0] csum_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            csum_q <= '0;
        end else if (launch) begin
            csum_q <= '0;
        end else if (hs) begin
            csum_q <= csum_q ^ m_data_o;
        end
    end

    assign csum_o = csum_q;
`endif

endmodule

// File: tb/tb_ob_drain_streamer.sv
// Randomized bench for ob_drain_streamer: SRAM model, bus monitor and
// per-transfer comparison against the expected window of the SRAM contents.
module tb_ob_drain_streamer;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        start_i;
    logic [7:0]  base_addr_i;
    logic [8:0]  num_words_i;
    logic        ob_mem_cenb_o;
    logic        ob_mem_wenb_o;
    logic [7:0]  ob_mem_addr_o;
    logic [31:0] ob_mem_data_i;
    logic [31:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        m_last_o;
    logic        busy_o;
    logic        done_o;
`ifdef OB_DRAIN_CSUM_EN
    logic [31:0] csum_o;
`endif

    always #5 clk_i = ~clk_i;

    ob_drain_streamer dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .num_words_i   (num_words_i),
        .ob_mem_cenb_o (ob_mem_cenb_o),
        .ob_mem_wenb_o (ob_mem_wenb_o),
        .ob_mem_addr_o (ob_mem_addr_o),
        .ob_mem_data_i (ob_mem_data_i),
        .m_data_o      (m_data_o),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_last_o      (m_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
`ifdef OB_DRAIN_CSUM_EN
        ,
        .csum_o        (csum_o)
`endif
    );

    logic [31:0] mem [256];

    always @(posedge clk_i) begin
        if (!ob_mem_cenb_o) ob_mem_data_i <= mem[ob_mem_addr_o];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    int          cyc = 0;
    int          en_cnt, hs_cnt, done_cnt, done_cyc, first_valid_cyc, last_hs_cyc;
    logic [31:0] got_q  [$];
    bit          last_q [$];
    logic [7:0]  addr_q [$];
    logic [31:0] csum_exp;
    bit          hold_q = 1'b0;
    logic [31:0] hold_data;

    task automatic clear_log();
        en_cnt = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1;
        first_valid_cyc = -1; last_hs_cyc = -1; csum_exp = '0;
        got_q.delete(); last_q.delete(); addr_q.delete();
    endtask

    initial begin
        clear_log();
        forever begin
            @(negedge clk_i);
            cyc++;
            if (rstn_i === 1'b1) begin
                chk("wenb_high", {31'b0, ob_mem_wenb_o}, 32'd1);
                if (!ob_mem_cenb_o) begin
                    en_cnt++;
                    addr_q.push_back(ob_mem_addr_o);
                end
                chk("outstanding_le2", {31'b0, (en_cnt - hs_cnt) <= 2}, 32'd1);
                if (hold_q) begin
                    chk("hold_valid", {31'b0, m_valid_o}, 32'd1);
                    chk("hold_data", m_data_o, hold_data);
                end
                if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (m_valid_o && m_ready_i) begin
                    got_q.push_back(m_data_o);
                    last_q.push_back(m_last_o);
                    hs_cnt++;
                    last_hs_cyc = cyc;
                    csum_exp ^= m_data_o;
                end
                hold_q    = m_valid_o && !m_ready_i;
                hold_data = m_data_o;
                if (done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
`ifdef OB_DRAIN_CSUM_EN
                    chk("csum_at_done", csum_o, csum_exp);
`endif
                end
            end else begin
                hold_q = 1'b0;
            end
        end
    end

    function automatic logic rdy(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return ((k % 6) == 0) || ((k % 6) == 3) || ((k % 6) == 5);
        endcase
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cenb"}, {31'b0, ob_mem_cenb_o}, 32'd1);
        chk({tag, "_addr"}, {24'b0, ob_mem_addr_o}, 32'd0);
        chk({tag, "_valid"}, {31'b0, m_valid_o}, 32'd0);
        chk({tag, "_last"}, {31'b0, m_last_o}, 32'd0);
        chk({tag, "_data"}, m_data_o, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
        chk({tag, "_done"}, {31'b0, done_o}, 32'd0);
    endtask

    task automatic run_xfer(input int base, input int num, input int mode);
        int t0;
        clear_log();
        @(negedge clk_i);
        start_i     = 1'b1;
        base_addr_i = 8'(base);
        num_words_i = 9'(num);
        m_ready_i   = rdy(mode, 0);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        t0 = cyc;
        @(negedge clk_i);
        #1;
        chk("busy_after_start", {31'b0, busy_o}, 32'd1);
        for (int k = 1; k < 4000 && done_cnt == 0; k++) begin
            @(posedge clk_i);
            #1;
            m_ready_i = rdy(mode, k);
        end
        if (done_cnt == 0) chk("timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("done_count", done_cnt, 32'd1);
        chk("busy_idle", {31'b0, busy_o}, 32'd0);
        chk("word_count", got_q.size(), num);
        chk("enable_count", en_cnt, num);
        for (int i = 0; i < got_q.size() && i < num; i++) begin
            chk("data", got_q[i], mem[(base + i) % 256]);
            chk("last", {31'b0, last_q[i]}, {31'b0, i == num - 1});
        end
        for (int i = 0; i < addr_q.size() && i < num; i++) begin
            chk("addr", {24'b0, addr_q[i]}, (base + i) % 256);
        end
        if (num > 0) begin
            chk("first_valid_lat", first_valid_cyc, t0 + 3);
            chk("done_lat", done_cyc, last_hs_cyc + 1);
        end else begin
            chk("zero_valid_never", first_valid_cyc, -1);
            chk("zero_done_lat", done_cyc, t0 + 1);
        end
    endtask

    initial begin
        rstn_i      = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        num_words_i = '0;
        m_ready_i   = 1'b0;
        fill_rand();
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_outputs("reset");
        rstn_i = 1'b1;

        // basic stream
        for (int i = 0; i < 8; i++) mem[i] = 32'h0A0B0C0D + i;
        run_xfer(0, 8, 0);

        // wraparound
        fill_rand();
        run_xfer(254, 4, 1);

        // backpressure 1,0,0,1,0,1...
        run_xfer($urandom_range(0, 255), 6, 2);

        // zero length
        run_xfer($urandom_range(0, 255), 0, 0);

        // whole buffer from a random base
        fill_rand();
        run_xfer($urandom_range(0, 255), 256, 1);

        for (int r = 0; r < 8; r++) begin
            fill_rand();
            run_xfer($urandom_range(0, 255), $urandom_range(1, 40), $urandom_range(0, 2));
        end

        // reset after 5 handshakes, then a fresh short run
        fill_rand();
        clear_log();
        @(negedge clk_i);
        start_i     = 1'b1;
        base_addr_i = 8'($urandom_range(0, 255));
        num_words_i = 9'd16;
        m_ready_i   = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        for (int k = 0; k < 2000 && hs_cnt < 5; k++) begin
            @(posedge clk_i);
            #1;
            m_ready_i = 1'($urandom_range(0, 1));
        end
        if (hs_cnt < 5) chk("abort_timeout", 32'd0, 32'd1);
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk_reset_outputs("abort");
        rstn_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        chk("abort_no_done", done_cnt, 32'd0);
        run_xfer($urandom_range(0, 255), 2, 1);

`ifdef OB_DRAIN_CSUM_EN
        mem[10] = 32'h01010101;
        mem[11] = 32'h02020202;
        mem[12] = 32'h04040404;
        run_xfer(10, 3, 1);
        chk("csum_hold", csum_o, 32'h07070707);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
